dcache_wb_buffer: RTL and testbench
===================================

// Module: dcache_wb_buffer
// PURPOSE
//  Multi-entry writeback buffer between the dcache controller and the memory port. Generalises the single-slot
//  writeback register to DEPTH lines.
//  Accepts evicted dirty lines and drains each line to memory as LINE_WIDTH/WORD_WIDTH word writes, in FIFO order.
//  Merges re-evictions of a queued line. Optionally forwards queued line data to load misses, so memory is never read stale.
// PARAMETERS
//  DEPTH       4    number of line entries (power of 2, >=2)
//  LINE_WIDTH  128  cache line width in bits (= DCACHE_LINE_WIDTH)
//  WORD_WIDTH  32   memory write beat width in bits (= XLEN)
//  ADDR_WIDTH  34   physical address width (= PLEN)
// PORTS
//  clk_i           in   1           clock
//  rst_i           in   1           synchronous reset, active-high
//  push_valid_i    in   1           controller offers an evicted dirty line
//  push_ready_o    out  1           buffer can accept (!full)
//  push_addr_i     in   ADDR_WIDTH  line address (offset bits ignored)
//  push_data_i     in   LINE_WIDTH  line data
//  mem_req_o       out  1           word write request
//  mem_gnt_i       in   1           request acknowledged by memory
//  mem_done_i      in   1           write completed by memory
//  mem_addr_o      out  ADDR_WIDTH  word-aligned write address
//  mem_wdata_o     out  WORD_WIDTH  write data
//  lookup_addr_i   in   ADDR_WIDTH  load-miss address to snoop
//  lookup_hit_o    out  1           a queued entry holds lookup line
//  lookup_data_o   out  LINE_WIDTH  that entry's line data
//  empty_o         out  1           no valid entries, no transfer in flight
// BEHAVIOUR
//  - Reset: all entries invalid, head/tail/count=0, drain FSM=IDLE.
//    Reset values: push_ready_o=1, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, lookup_hit_o=0, lookup_data_o=0, empty_o=1.
//  - Reset mid-drain drops every entry. mem_req_o is 0 the cycle after rst_i is sampled high.
//  - Push handshake: accepted on push_valid_i && push_ready_o at a clock edge. push_ready_o = (count != DEPTH).
//    Ready does not depend on a same-cycle pop.
//  - Merge: if a valid entry other than the one currently draining holds the same line address, the accepted push
//    overwrites that entry's data. count is unchanged. Merge is allowed even when full, so push_ready_o=1 for a matching address.
//  - A push matching the draining head allocates a new tail entry. The head drain is not altered.
//  - A pushed entry is visible to lookup and the FSM one cycle after acceptance.
//  - Drain FSM:
//      IDLE -> REQ when count != 0; beat=0.
//      REQ: mem_req_o=1; mem_addr_o = head_addr | beat*WORD_WIDTH/8; mem_wdata_o = head_data[beat*WORD_WIDTH +: WORD_WIDTH].
//           Address and data are held stable until mem_gnt_i. mem_gnt_i -> WAIT_DONE.
//      WAIT_DONE: mem_req_o=0. On mem_done_i:
//           if beat != last, beat++ and -> REQ;
//           else pop head (invalidate, head++ with wrap, count--) and -> IDLE.
//    mem_gnt_i and mem_done_i in the same REQ cycle count as gnt only. done is ignored outside WAIT_DONE.
//  - Beat 0 is issued first. Minimum latency, push to first mem_req_o: 2 cycles (accept edge, IDLE edge).
//  - Simultaneous push and pop: both apply. count stays the same. head/tail pointers wrap modulo DEPTH.
//  - empty_o = (count==0) && FSM==IDLE. The controller must wait for empty_o before fence completion.
//  - Lookup is combinational. It compares line addresses of valid entries, draining head included.
//    On multiple matches it returns the youngest, i.e. nearest tail.
// CONFIGURATION
//  - DCACHE_WB_FORWARD_EN defined: lookup_hit_o/lookup_data_o are driven as above.
//  - Undefined: both outputs are tied 0 and no compare logic is built. The controller must stall load misses
//    whose line matches until empty_o. Merge logic is present in both builds.
// TESTING
//  - Push line 0x1000 (data word k = 0xA0+k) into an empty buffer, gnt/done after 1 cycle each ->
//    4 writes at 0x1000,0x1004,0x1008,0x100C with 0xA0..0xA3; then empty_o=1.
//  - Push 4 distinct lines while mem_gnt_i is held 0 -> push_ready_o=0 after the 4th.
//    A 5th distinct push is stalled; a 5th push matching entry 2 is accepted and its data is overwritten.
//  - Push 0x2000, then 0x2000 again while beat 1 is in flight -> the first drain completes with old data,
//    then a second full drain with new data follows.
//  - FORWARD_EN: queue 0x3000 and 0x4000, lookup 0x4008 -> lookup_hit_o=1 with 0x4000 data. Lookup 0x5000 -> lookup_hit_o=0.
//  - Assert rst_i while in WAIT_DONE with 3 entries queued -> next cycle mem_req_o=0, empty_o=1, push_ready_o=1.
//    A stale mem_done_i is ignored.

Source files
------------

// File: rtl/dcache_wb_buffer_if.sv
// Bundle of push, memory-write, lookup and status signals between the dcache
// controller and the writeback buffer. Names are as seen from the buffer.
interface dcache_wb_buffer_if #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 34
);
    logic                  push_valid_i;
    logic                  push_ready_o;
    logic [ADDR_WIDTH-1:0] push_addr_i;
    logic [LINE_WIDTH-1:0] push_data_i;
    logic                  mem_req_o;
    logic                  mem_gnt_i;
    logic                  mem_done_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WORD_WIDTH-1:0] mem_wdata_o;
    logic [ADDR_WIDTH-1:0] lookup_addr_i;
    logic                  lookup_hit_o;
    logic [LINE_WIDTH-1:0] lookup_data_o;
    logic                  empty_o;

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i,
        input  mem_gnt_i, mem_done_i, lookup_addr_i,
        output push_ready_o, mem_req_o, mem_addr_o, mem_wdata_o,
        output lookup_hit_o, lookup_data_o, empty_o
    );

    modport master (
        output push_valid_i, push_addr_i, push_data_i,
        output mem_gnt_i, mem_done_i, lookup_addr_i,
        input  push_ready_o, mem_req_o, mem_addr_o, mem_wdata_o,
        input  lookup_hit_o, lookup_data_o, empty_o
    );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Multi-entry FIFO writeback buffer: merges re-evicted lines, drains each line as word writes.
// Define DCACHE_WB_FORWARD_EN to build the load-miss lookup/forwarding path.
module dcache_wb_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 34
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_wb_buffer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int N_BEATS = LINE_WIDTH / WORD_WIDTH;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
    localparam int BYTE_SH = $clog2(WORD_WIDTH / 8);
    localparam int TAG_W   = ADDR_WIDTH - OFF_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(N_BEATS - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Entry storage: line tag (address without offset), data and valid flag
    logic [TAG_W-1:0]      tag_q  [DEPTH];
    logic [LINE_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [TAG_W-1:0]  push_tag;
    logic              draining;
    logic [DEPTH-1:0]  merge_match;
    logic              merge_hit;
    logic [PTR_W-1:0]  merge_idx;
    logic              push_ready;
    logic              push_fire;
    logic              alloc;
    logic              merge;
    logic              pop;

    assign push_tag = bus.push_addr_i[ADDR_WIDTH-1:OFF_W];
    assign draining = (state_q != ST_IDLE);

    // The head under drain is excluded so its beats never change mid-transfer
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_merge
        assign merge_match[gi] = valid_q[gi] && (tag_q[gi] == push_tag)
                                 && !(draining && (head_q == PTR_W'(gi)));
    end

    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (merge_match[k]) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(k);
            end
        end
    end

    assign push_ready = (count_q != FULL_COUNT) || merge_hit;
    assign push_fire  = bus.push_valid_i && push_ready;
    assign alloc      = push_fire && !merge_hit;
    assign merge      = push_fire && merge_hit;
    assign pop        = (state_q == ST_WAIT) && bus.mem_done_i && (beat_q == LAST_BEAT);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (alloc) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (alloc && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !alloc) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                    beat_d  = '0;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_done_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= push_tag;
                data_q[tail_q]  <= bus.push_data_i;
            end
            if (merge) begin
                data_q[merge_idx] <= bus.push_data_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    logic [LINE_WIDTH-1:0] head_line;
    logic                  req_active;

    assign head_line  = data_q[head_q];
    assign req_active = (state_q == ST_REQ);

    assign bus.push_ready_o = push_ready;
    assign bus.mem_req_o    = req_active;
    assign bus.mem_addr_o   = req_active
                              ? ({tag_q[head_q], OFF_W'(0)} | (ADDR_WIDTH'(beat_q) << BYTE_SH))
                              : '0;
    assign bus.mem_wdata_o  = req_active ? head_line[beat_q*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign bus.empty_o      = (count_q == '0) && (state_q == ST_IDLE);

`ifdef DCACHE_WB_FORWARD_EN
    logic [TAG_W-1:0]      lookup_tag;
    logic [DEPTH-1:0]      lookup_match;
    logic [PTR_W-1:0]      lk_idx;
    logic                  lookup_hit;
    logic [LINE_WIDTH-1:0] lookup_data;
    logic                  unused_offsets;

    assign lookup_tag     = bus.lookup_addr_i[ADDR_WIDTH-1:OFF_W];
    assign unused_offsets = ^{bus.push_addr_i[OFF_W-1:0], bus.lookup_addr_i[OFF_W-1:0]};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup
        assign lookup_match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag);
    end

    // Walk oldest to youngest so the last match (nearest tail) wins
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head_q + PTR_W'(k);
            if (lookup_match[lk_idx]) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[lk_idx];
            end
        end
    end

    assign bus.lookup_hit_o  = lookup_hit;
    assign bus.lookup_data_o = lookup_data;
`else
    logic unused_offsets;

    assign unused_offsets    = ^{bus.push_addr_i[OFF_W-1:0], bus.lookup_addr_i};
    assign bus.lookup_hit_o  = 1'b0;
    assign bus.lookup_data_o = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Scoreboard bench for dcache_wb_buffer: expected memory writes are queued by the
// stimulus and checked by a monitor on every granted request.
module tb_dcache_wb_buffer;
    localparam int AW = 34;
    localparam int LW = 128;
    localparam int WW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mem_auto = 1'b0;
    int   checks = 0;
    int   failures = 0;
    beat_t exp_q[$];

    dcache_wb_buffer_if #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    dcache_wb_buffer #(.DEPTH(4), .LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_line(input logic [AW-1:0] a, input logic [LW-1:0] d);
        for (int k = 0; k < LW / WW; k++) begin
            exp_q.push_back('{addr: a + AW'(4 * k), data: d[k*WW +: WW]});
        end
    endtask

    task automatic push_line(input logic [AW-1:0] a, input logic [LW-1:0] d);
        int n;
        n = 0;
        bus.push_valid_i = 1'b1;
        bus.push_addr_i  = a;
        bus.push_data_i  = d;
        while (!bus.push_ready_o && n < 200) begin
            step();
            n++;
        end
        if (!bus.push_ready_o) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=ready0 required=ready1 addr=%0h", a);
        end
        step();
        bus.push_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (!(bus.empty_o && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_empty"}, LW'(bus.empty_o), LW'(1));
        check({name, "_queue_left"}, LW'(exp_q.size()), LW'(0));
    endtask

    task automatic mem_manual();
        mem_auto = 1'b0;
        step();
        bus.mem_gnt_i  = 1'b0;
        bus.mem_done_i = 1'b0;
    endtask

    // Memory model: grant one cycle after a request is seen, done one cycle after the grant
    initial begin
        int rs;
        rs = 0;
        forever begin
            step();
            if (!mem_auto) begin
                rs = 0;
            end else begin
                case (rs)
                    0: if (bus.mem_req_o) rs = 1;
                    1: begin bus.mem_gnt_i = 1'b1; rs = 2; end
                    2: begin bus.mem_gnt_i = 1'b0; rs = 3; end
                    3: begin bus.mem_done_i = 1'b1; rs = 4; end
                    default: begin bus.mem_done_i = 1'b0; rs = 0; end
                endcase
            end
        end
    end

    // Monitor: every accepted word write is compared with the oldest expected beat
    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus.mem_req_o && bus.mem_gnt_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", bus.mem_addr_o, bus.mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0h data=%0h expected %0h:%0h", bus.mem_addr_o, bus.mem_wdata_o, e.addr, e.data);
                if (bus.mem_addr_o !== e.addr || bus.mem_wdata_o !== e.data) begin
                    failures++;
                    $display("FAIL mem_write actual=%0h:%0h required=%0h:%0h",
                             bus.mem_addr_o, bus.mem_wdata_o, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] la, lb, lc, lc2, ld, lx, ly, lp, lq, lr, ls;
        la  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lb  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        lc  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        lc2 = {32'hCC03, 32'hCC02, 32'hCC01, 32'hCC00};
        ld  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        lx  = {32'h1113, 32'h1112, 32'h1111, 32'h1110};
        ly  = {32'h2223, 32'h2222, 32'h2221, 32'h2220};
        lp  = {32'h3003, 32'h3002, 32'h3001, 32'h3000};
        lq  = {32'h4003, 32'h4002, 32'h4001, 32'h4000};
        lr  = {32'h6003, 32'h6002, 32'h6001, 32'h6000};
        ls  = {32'h7003, 32'h7002, 32'h7001, 32'h7000};

        bus.push_valid_i  = 1'b0;
        bus.push_addr_i   = '0;
        bus.push_data_i   = '0;
        bus.mem_gnt_i     = 1'b0;
        bus.mem_done_i    = 1'b0;
        bus.lookup_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_push_ready", LW'(bus.push_ready_o), LW'(1));
        check("rst_mem_req", LW'(bus.mem_req_o), LW'(0));
        check("rst_mem_addr", LW'(bus.mem_addr_o), LW'(0));
        check("rst_mem_wdata", LW'(bus.mem_wdata_o), LW'(0));
        check("rst_lookup_hit", LW'(bus.lookup_hit_o), LW'(0));
        check("rst_lookup_data", bus.lookup_data_o, LW'(0));
        check("rst_empty", LW'(bus.empty_o), LW'(1));
        rst = 1'b0;

        // Single line drain with two-cycle push-to-request latency
        mem_auto = 1'b1;
        exp_line(34'h1000, la);
        push_line(34'h1000, la);
        check("lat_req_after_accept", LW'(bus.mem_req_o), LW'(0));
        check("lat_empty_after_accept", LW'(bus.empty_o), LW'(0));
        step();
        check("lat_req_second_edge", LW'(bus.mem_req_o), LW'(1));
        check("lat_first_addr", LW'(bus.mem_addr_o), LW'(34'h1000));
        wait_empty("single", 200);

        // Fill while memory stalls; full blocks distinct and draining-head pushes, merge still allowed
        mem_manual();
        push_line(34'h8000, lb);
        push_line(34'h8040, lc);
        push_line(34'h8080, lc);
        push_line(34'h80C0, ld);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i  = 34'h9000;
        bus.push_data_i  = la;
        #1;
        check("full_ready_distinct", LW'(bus.push_ready_o), LW'(0));
        step();
        check("full_stall_held", LW'(bus.push_ready_o), LW'(0));
        bus.push_addr_i = 34'h8000;
        #1;
        check("full_ready_draining_head", LW'(bus.push_ready_o), LW'(0));
        bus.push_addr_i = 34'h8084;
        bus.push_data_i = lc2;
        #1;
        check("full_ready_merge", LW'(bus.push_ready_o), LW'(1));
        step();
        bus.push_valid_i = 1'b0;
        bus.push_addr_i  = 34'h9000;
        #1;
        check("full_after_merge", LW'(bus.push_ready_o), LW'(0));
        check("full_not_empty", LW'(bus.empty_o), LW'(0));
        exp_line(34'h8000, lb);
        exp_line(34'h8040, lc);
        exp_line(34'h8080, lc2);
        exp_line(34'h80C0, ld);
        mem_auto = 1'b1;
        wait_empty("full_drain", 400);

        // Re-eviction of the draining line queues a second full drain
        exp_line(34'h2000, lx);
        push_line(34'h2000, lx);
        begin
            int n;
            n = 0;
            while (!(bus.mem_req_o && bus.mem_addr_o == 34'h2004) && n < 100) begin
                step();
                n++;
            end
            check("reevict_beat1_seen", LW'(bus.mem_addr_o), LW'(34'h2004));
        end
        exp_line(34'h2000, ly);
        push_line(34'h2000, ly);
        wait_empty("reevict", 300);

        // Lookup against queued lines, then reset while waiting for done
        mem_manual();
        push_line(34'h3000, lp);
        push_line(34'h4000, lq);
        bus.lookup_addr_i = 34'h4008;
        #1;
`ifdef DCACHE_WB_FORWARD_EN
        check("lookup_4008_hit", LW'(bus.lookup_hit_o), LW'(1));
        check("lookup_4008_data", bus.lookup_data_o, lq);
        bus.lookup_addr_i = 34'h3004;
        #1;
        check("lookup_head_hit", LW'(bus.lookup_hit_o), LW'(1));
        check("lookup_head_data", bus.lookup_data_o, lp);
`else
        check("lookup_off_hit", LW'(bus.lookup_hit_o), LW'(0));
        check("lookup_off_data", bus.lookup_data_o, LW'(0));
`endif
        bus.lookup_addr_i = 34'h5000;
        #1;
        check("lookup_5000_hit", LW'(bus.lookup_hit_o), LW'(0));
        push_line(34'h6000, lr);
        check("three_queued_ready", LW'(bus.push_ready_o), LW'(1));
        check("head_requesting", LW'(bus.mem_req_o), LW'(1));
        exp_q.push_back('{addr: 34'h3000, data: 32'h3000});
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        check("wait_done_req_low", LW'(bus.mem_req_o), LW'(0));
        check("wait_done_not_empty", LW'(bus.empty_o), LW'(0));
        bus.lookup_addr_i = 34'h3004;
        rst = 1'b1;
        bus.mem_done_i = 1'b1;
        step();
        check("midrst_mem_req", LW'(bus.mem_req_o), LW'(0));
        check("midrst_empty", LW'(bus.empty_o), LW'(1));
        check("midrst_ready", LW'(bus.push_ready_o), LW'(1));
        check("midrst_lookup_hit", LW'(bus.lookup_hit_o), LW'(0));
        rst = 1'b0;
        step();
        bus.mem_done_i = 1'b0;
        check("stale_done_req", LW'(bus.mem_req_o), LW'(0));
        check("stale_done_empty", LW'(bus.empty_o), LW'(1));
        check("midrst_queue_left", LW'(exp_q.size()), LW'(0));
        bus.lookup_addr_i = '0;

        // Normal operation resumes after the mid-drain reset
        mem_auto = 1'b1;
        exp_line(34'h7000, ls);
        push_line(34'h7000, ls);
        wait_empty("post_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
